// File: rtl/bus_result_monitor.sv
// rtl/bus_result_monitor.sv - CPU write-bus monitor producing a hardware test verdict
module bus_result_monitor #(
    parameter logic [15:0] CHECK_ADDR = 16'h022A,
    parameter logic [7:0]  EXPECT     = 8'h55,
    parameter logic [15:0] ROM_BASE   = 16'hF000,
    parameter logic [15:0] TIMEOUT    = 16'd200
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic        done,
    output logic        pass,
    output logic [1:0]  cause,
    output logic [7:0]  result,
    output logic [15:0] wcount,
    output logic [15:0] cycles
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [1:0]  CAUSE_NONE    = 2'd0;
    localparam logic [1:0]  CAUSE_VALUE   = 2'd1;
    localparam logic [1:0]  CAUSE_ROM     = 2'd2;
    localparam logic [1:0]  CAUSE_TIMEOUT = 2'd3;
    localparam logic [15:0] TIMEOUT_LAST  = TIMEOUT - 16'd1;

    state_t      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [7:0]  result_q, result_d;
    logic [15:0] wcount_q, wcount_d;
    logic [15:0] cycles_q, cycles_d;

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            cause_q  <= CAUSE_NONE;
            result_q <= 8'h00;
            wcount_q <= 16'h0000;
            cycles_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            result_q <= result_d;
            wcount_q <= wcount_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        result_d = result_q;
        wcount_d = wcount_q;
        cycles_d = cycles_q;
        if (state_q == ST_RUN) begin
            if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
            if (we && (wcount_q != 16'hFFFF)) wcount_d = wcount_q + 16'd1;
            // A deciding write outranks the timeout landing on the same edge.
            if (we && (addr >= ROM_BASE)) begin
                state_d  = ST_FAIL;
                cause_d  = CAUSE_ROM;
                result_d = wdata;
            end else if (we && (addr == CHECK_ADDR) && (wdata == EXPECT)) begin
                state_d  = ST_PASS;
                cause_d  = CAUSE_NONE;
                result_d = wdata;
            end else if (we && (addr == CHECK_ADDR)) begin
                state_d  = ST_FAIL;
                cause_d  = CAUSE_VALUE;
                result_d = wdata;
            end else if (cycles_q == TIMEOUT_LAST) begin
                state_d  = ST_FAIL;
                cause_d  = CAUSE_TIMEOUT;
                result_d = 8'h00;
            end
        end
    end

    assign done   = (state_q != ST_RUN);
    assign pass   = (state_q == ST_PASS);
    assign cause  = cause_q;
    assign result = result_q;
    assign wcount = wcount_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_bus_result_monitor.sv
// tb/tb_bus_result_monitor.sv - directed and randomized checks of bus_result_monitor
module tb_bus_result_monitor;

    localparam int TMO = 200;

    logic        ph2 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        we_a = 1'b0, we_b = 1'b0, we_c = 1'b0;

    logic        done_a, pass_a, done_b, pass_b, done_c, pass_c;
    logic [1:0]  cause_a, cause_b, cause_c;
    logic [7:0]  result_a, result_b, result_c;
    logic [15:0] wcount_a, cycles_a, wcount_b, cycles_b, wcount_c, cycles_c;

    int checks = 0;
    int errors = 0;

    logic        s_we   [0:TMO+3];
    logic [15:0] s_addr [0:TMO+3];
    logic [7:0]  s_data [0:TMO+3];

    always #5 ph2 = ~ph2;

    bus_result_monitor dut_a (
        .ph2(ph2), .reset(reset), .addr(addr), .wdata(wdata), .we(we_a),
        .done(done_a), .pass(pass_a), .cause(cause_a), .result(result_a),
        .wcount(wcount_a), .cycles(cycles_a)
    );

    bus_result_monitor #(.TIMEOUT(16'hFFFF)) dut_b (
        .ph2(ph2), .reset(reset), .addr(addr), .wdata(wdata), .we(we_b),
        .done(done_b), .pass(pass_b), .cause(cause_b), .result(result_b),
        .wcount(wcount_b), .cycles(cycles_b)
    );

    bus_result_monitor #(.TIMEOUT(16'd1)) dut_c (
        .ph2(ph2), .reset(reset), .addr(addr), .wdata(wdata), .we(we_c),
        .done(done_c), .pass(pass_c), .cause(cause_c), .result(result_c),
        .wcount(wcount_c), .cycles(cycles_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic d, input logic p, input logic [1:0] c,
                         input logic [7:0] r, input logic [15:0] w, input logic [15:0] cy);
        chk({tag, ".done"},   done_a,   d);
        chk({tag, ".pass"},   pass_a,   p);
        chk({tag, ".cause"},  cause_a,  c);
        chk({tag, ".result"}, result_a, r);
        chk({tag, ".wcount"}, wcount_a, w);
        chk({tag, ".cycles"}, cycles_a, cy);
    endtask

    task automatic do_reset();
        we_a = 0; we_b = 0; we_c = 0;
        reset = 1'b1;
        @(posedge ph2); #1;
        reset = 1'b0;
    endtask

    task automatic step(input logic w, input logic [15:0] a, input logic [7:0] d);
        we_a = w; addr = a; wdata = d;
        @(posedge ph2); #1;
        we_a = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h1234, 8'h00);
    endtask

    // Reference: walk the write schedule against the verdict rules, stopping at the first verdict.
    task automatic model(output int dec_edge, output logic p, output logic [1:0] c,
                         output logic [7:0] r, output int wc);
        dec_edge = 0; p = 0; c = 0; r = 0; wc = 0;
        for (int e = 1; e <= TMO; e++) begin
            if (s_we[e]) begin
                wc++;
                if (s_addr[e] >= 16'hF000) begin
                    dec_edge = e; c = 2; r = s_data[e]; return;
                end
                if (s_addr[e] == 16'h022A) begin
                    dec_edge = e; r = s_data[e];
                    if (s_data[e] == 8'h55) p = 1; else c = 1;
                    return;
                end
            end
            if (e == TMO) begin
                dec_edge = e; c = 3; r = 0; return;
            end
        end
    endtask

    initial begin
        int          dec_edge, wc, dp;
        logic        ep;
        logic [1:0]  ec;
        logic [7:0]  er;
        logic [15:0] ra;

        #2;
        chk_a("reset_async", 0, 0, 0, 8'h00, 0, 0);
        do_reset();
        chk_a("reset_vals", 0, 0, 0, 8'h00, 0, 0);

        // Test-plan pass sequence: writes on cycles 5 and 9 (edges 6 and 10).
        idle(5);
        step(1, 16'h0200, 8'h10);
        idle(3);
        chk("pass_seq.pre_done", done_a, 1'b0);
        step(1, 16'h022A, 8'h55);
        chk_a("pass_seq", 1, 1, 0, 8'h55, 2, 10);
        chk("tmo1.done", done_c, 1'b1);
        chk("tmo1.cause", cause_c, 2'd3);
        chk("tmo1.cycles", cycles_c, 16'd1);

        do_reset();
        chk("tmo1.reset", done_c, 1'b0);
        step(1, 16'h022A, 8'h54);
        chk_a("wrong_val", 1, 0, 1, 8'h54, 1, 1);
        step(1, 16'h022A, 8'h55);
        idle(3);
        chk_a("after_verdict", 1, 0, 1, 8'h54, 1, 1);

        do_reset();
        step(1, 16'hF123, 8'hAA);
        chk_a("rom_write", 1, 0, 2, 8'hAA, 1, 1);
        do_reset();
        step(1, 16'hFFFF, 8'h55);
        chk_a("rom_top", 1, 0, 2, 8'h55, 1, 1);

        do_reset();
        idle(TMO - 1);
        chk_a("tmo_pre", 0, 0, 0, 8'h00, 0, TMO - 1);
        idle(1);
        chk_a("tmo", 1, 0, 3, 8'h00, 0, TMO);
        do_reset();
        idle(TMO - 1);
        step(1, 16'h022A, 8'h55);
        chk_a("tmo_edge_pass", 1, 1, 0, 8'h55, 1, TMO);

        do_reset();
        for (int i = 0; i < 3; i++) step(1, 16'h0100, 8'(i));
        #2 reset = 1'b1;
        #1 chk_a("mid_reset", 0, 0, 0, 8'h00, 0, 0);
        @(posedge ph2); #1 reset = 1'b0;
        idle(2);
        step(1, 16'h022A, 8'h55);
        chk_a("fresh_pass", 1, 1, 0, 8'h55, 1, 3);
        #2 reset = 1'b1;
        #1 chk_a("reset_after_pass", 0, 0, 0, 8'h00, 0, 0);
        @(posedge ph2); #1 reset = 1'b0;
        step(1, 16'h022A, 8'h33);
        chk_a("fresh_fail", 1, 0, 1, 8'h33, 1, 1);

        // Randomized schedules against the reference model.
        for (int t = 0; t < 20; t++) begin
            dp = $urandom_range(0, 2);
            for (int e = 0; e <= TMO + 3; e++) begin
                s_we[e] = 1'b0; s_addr[e] = 16'($urandom); s_data[e] = 8'($urandom);
                if ($urandom_range(0, 99) < 30) begin
                    s_we[e] = 1'b1;
                    if ($urandom_range(0, 99) < dp) begin
                        s_addr[e] = 16'h022A;
                        if ($urandom_range(0, 1) == 1) s_data[e] = 8'h55;
                    end else if ($urandom_range(0, 99) < dp) begin
                        s_addr[e] = 16'hF000 + 16'($urandom_range(0, 16'h0FFF));
                    end else begin
                        ra = 16'($urandom_range(0, 16'hEFFF));
                        s_addr[e] = (ra == 16'h022A) ? 16'h0300 : ra;
                    end
                end
            end
            model(dec_edge, ep, ec, er, wc);
            do_reset();
            for (int e = 1; e <= TMO + 3; e++) begin
                step(s_we[e], s_addr[e], s_data[e]);
                chk($sformatf("rnd%0d.done@%0d", t, e), done_a, (e >= dec_edge));
            end
            chk_a($sformatf("rnd%0d", t), 1, ep, ec, er, 16'(wc), 16'(dec_edge));
        end

        // Maximum timeout with continuous writes: wcount saturates, timeout still wins.
        do_reset();
        we_b = 1'b1; addr = 16'h0300; wdata = 8'h77;
        for (int i = 1; i <= 70000; i++) begin
            @(posedge ph2); #1;
            if (i == 65534) begin
                chk("long.pre_done", done_b, 1'b0);
                chk("long.pre_wcount", wcount_b, 16'd65534);
            end
            if (i == 65535) begin
                chk("long.done", done_b, 1'b1);
                chk("long.cause", cause_b, 2'd3);
                chk("long.result", result_b, 8'h00);
                chk("long.cycles", cycles_b, 16'hFFFF);
            end
        end
        we_b = 1'b0;
        chk("long.wcount_sat", wcount_b, 16'hFFFF);
        chk("long.pass", pass_b, 1'b0);
        chk("long.cycles_frozen", cycles_b, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_result_monitor.md
# bus_result_monitor

Single-clock monitor on the CPU-to-memory bus between the 6502 core and the `mem` block. It watches every bus write and reports a test verdict in hardware instead of leaving it to a timed assertion. The verdict comes from a write of an expected value to a result address, an illegal write into ROM space, or a cycle-count timeout. Every SuiteA regression bench instantiates it beside `top.mem` and waits on `done`.

## Interface
- `CHECK_ADDR`, 16'h022A: RAM address the test program writes its result to.
- `EXPECT`, 8'h55: value at `CHECK_ADDR` that means pass.
- `ROM_BASE`, 16'hF000: lowest ROM address; any write at or above it is illegal.
- `TIMEOUT`, 16'd200: cycles after reset release with no verdict before the monitor declares failure.
- `ph2`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  16  CPU address bus.
- `wdata`  in  8  CPU write data.
- `we`  in  1  write strobe, one cycle per bus write.
- `done`  out  1  verdict reached; sticky until reset.
- `pass`  out  1  verdict is pass; valid only while `done`=1.
- `cause`  out  2  failure cause: 0 none, 1 wrong value, 2 ROM write, 3 timeout.
- `result`  out  8  `wdata` captured on the deciding write; 0 on timeout.
- `wcount`  out  16  number of bus writes accepted in RUN, saturating at 16'hFFFF.
- `cycles`  out  16  cycles spent in RUN, saturating at 16'hFFFF.

## Operation
- States: RUN, PASS, FAIL. Reset forces RUN.
- PASS and FAIL are terminal. Only `reset` leaves them.
- In RUN, each cycle is evaluated in this priority order; the first matching rule applies:
  1. `we`=1 and `addr` >= `ROM_BASE` -> FAIL, `cause`=2, `result`=`wdata`.
  2. `we`=1 and `addr`==`CHECK_ADDR` and `wdata`==`EXPECT` -> PASS, `cause`=0, `result`=`wdata`.
  3. `we`=1 and `addr`==`CHECK_ADDR` and `wdata`!=`EXPECT` -> FAIL, `cause`=1, `result`=`wdata`.
  4. `cycles`==`TIMEOUT`-1 with no rule above matching -> FAIL, `cause`=3, `result`=0.
- `wcount` increments on every `we`=1 cycle in RUN, including the deciding write. It is frozen outside RUN.
- `cycles` increments on every cycle in RUN, including the deciding cycle. It is frozen outside RUN.
- Both counters saturate at 16'hFFFF and never wrap.
- Bus reads are ignored. `we` with `addr` in the range 0..`ROM_BASE`-1 other than `CHECK_ADDR` only increments `wcount`.
- Outputs are derived from the state: `done` = (state != RUN); `pass` = (state == PASS).
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Reset values: `done`=0, `pass`=0, `cause`=0, `result`=0, `wcount`=0, `cycles`=0, state RUN.
- Reset takes effect immediately on assertion, independent of `ph2`.
- Asserting `reset` mid-test or after a verdict clears everything to the reset values. Counting resumes on the first `ph2` edge after release.
- Latency: a deciding write sampled on edge N gives `done`=1 and valid `pass`/`cause`/`result` after edge N. `wcount` includes that write.
- Timeout: with no writes, `done` rises after edge `TIMEOUT` following reset release, and `cycles` then reads `TIMEOUT`.
- A deciding write on the same edge as the timeout boundary takes priority. The verdict is that write's, never a timeout.
- Writes after a verdict change nothing: no `wcount` increment and no verdict change, even when the value at `CHECK_ADDR` is correct.
- `TIMEOUT`=0 is unsupported. `TIMEOUT`=1 gives `done` after the first edge.

## Test plan
- Writes 0x10@0x0200, 0x55@0x022A at cycles 5 and 9 -> `done`/`pass`=1 after cycle 9, `cause`=0, `result`=0x55, `wcount`=2, `cycles`=10.
- Write 0x54@0x022A -> `pass`=0, `cause`=1, `result`=0x54. A following write of 0x55@0x022A leaves the verdict unchanged and `wcount`=1.
- Write 0xAA@0xF123 -> FAIL, `cause`=2, `result`=0xAA. A write of 0x55@0xFFFF as the first deciding write also gives `cause`=2.
- No writes, `TIMEOUT`=200 -> `done` rises exactly after edge 200, `cause`=3, `result`=0, `cycles`=200. A correct write on edge 200 instead gives PASS.
- Reset asserted mid-edge-interval after 3 writes and again after a PASS -> all outputs 0 at once. The next test produces a correct fresh verdict.
- `TIMEOUT`=16'hFFFF with 70000 writes to 0x0300 -> no verdict before the timeout boundary. `wcount` holds 16'hFFFF once saturated. `done` with `cause`=3 after edge 65535.
